// File: rtl/mips_alu_pkg.sv
// Shared ALU opcode encodings and datapath width for the EXE stage and the ALU-control decoder.
package mips_alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_ADDU = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [1:0] SHIFT_SLL = 2'd0;
  localparam logic [1:0] SHIFT_SRL = 2'd1;
  localparam logic [1:0] SHIFT_SRA = 2'd2;

endpackage

// File: rtl/alu_barrel_shifter.sv
// Combinational barrel shifter covering MIPS SLL/SRL/SRA.
module alu_barrel_shifter
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned ShW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [ShW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    case (mode)
      SHIFT_SLL: result = data << shamt;
      SHIFT_SRL: result = data >> shamt;
      SHIFT_SRA: result = $unsigned($signed(data) >>> shamt);
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// EXE-stage integer ALU: 14 operations, registered result plus zero and signed-overflow flags.
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             overflow
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum, diff, shift_res, result_d;
  logic [1:0]       shift_mode;
  logic             ovf_d, slt, sltu;
  logic             sign_a, sign_b;

  assign sign_a = data1[WIDTH-1];
  assign sign_b = data2[WIDTH-1];
  assign sum    = data1 + data2;
  assign diff   = data1 - data2;

  // On differing signs the negative operand is smaller; only equal signs trust the difference.
  assign slt  = (sign_a != sign_b) ? sign_a : diff[WIDTH-1];
  assign sltu = data1 < data2;

  always_comb begin
    shift_mode = SHIFT_SLL;
    case (alu_op)
      ALU_SRL: shift_mode = SHIFT_SRL;
      ALU_SRA: shift_mode = SHIFT_SRA;
      default: shift_mode = SHIFT_SLL;
    endcase
  end

  alu_barrel_shifter #(
    .WIDTH(WIDTH),
    .ShW  (ShW)
  ) u_shifter (
    .data  (data2),
    .shamt (data1[ShW-1:0]),
    .mode  (shift_mode),
    .result(shift_res)
  );

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    case (alu_op)
      ALU_AND:  result_d = data1 & data2;
      ALU_OR:   result_d = data1 | data2;
      ALU_ADD: begin
        result_d = sum;
        ovf_d    = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
      end
      ALU_XOR:  result_d = data1 ^ data2;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  result_d = shift_res;
      ALU_SUB: begin
        result_d = diff;
        ovf_d    = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
      end
      ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, sltu};
      ALU_ADDU: result_d = sum;
      ALU_SUBU: result_d = diff;
      ALU_NOR:  result_d = ~(data1 | data2);
      ALU_LUI:  result_d = {{(WIDTH-16){1'b0}}, data2[15:0]} << 16;
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      zero_flag  <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      alu_result <= result_d;
      zero_flag  <= (result_d == '0);
      overflow   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu using a queue of expected results.
module tb_mips_alu;
  import mips_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] data1, data2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        zero_flag, overflow;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mips_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data1     (data1),
    .data2     (data2),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .zero_flag (zero_flag),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] op,
                       input logic [31:0] res, input logic ovf, input string name);
    exp_t e;
    data1  = d1;
    data2  = d2;
    alu_op = op;
    e.res  = res;
    e.zero = (res == 32'h0);
    e.ovf  = ovf;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data1  = $urandom;
      data2  = $urandom;
      alu_op = 4'($urandom_range(0, 15));
      n_checks++;
      if (alu_result !== 32'h0 || zero_flag !== 1'b1 || overflow !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold: got res=%h z=%b ovf=%b, want res=00000000 z=1 ovf=0",
                 alu_result, zero_flag, overflow);
      end
    end
    // Release at a negedge; the first result must appear after the following posedge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'd7, 32'd9, ALU_ADD, 32'd16, 1'b0, "post_reset_first");
    @(negedge clk);
    begin
      exp_t e = sb.pop_front();
      n_checks++;
      if (alu_result !== e.res || zero_flag !== e.zero || overflow !== e.ovf) begin
        n_errors++;
        $display("FAIL %s: got res=%h z=%b ovf=%b, want res=%h z=%b ovf=%b", e.name,
                 alu_result, zero_flag, overflow, e.res, e.zero, e.ovf);
      end
    end
    // Nonzero overflowing result in flight, then reset between edges.
    drive(32'h7FFFFFFF, 32'h1, ALU_ADD, 32'h80000000, 1'b1, "unused");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if (alu_result !== 32'h0 || zero_flag !== 1'b1 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: got res=%h z=%b ovf=%b, want res=00000000 z=1 ovf=0",
               alu_result, zero_flag, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub;
    logic [31:0] d1 [6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h80000000,
                            32'h0};
    logic [31:0] d2 [6] = '{32'h1, 32'h1, 32'd5, 32'h1, 32'h1, 32'h1};
    logic [3:0]  op [6] = '{ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUB, ALU_SUBU, ALU_SUB};
    logic [31:0] rs [6] = '{32'h80000000, 32'h80000000, 32'h0, 32'h7FFFFFFF, 32'h7FFFFFFF,
                            32'hFFFFFFFF};
    logic        ov [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e = sb.pop_front();
        n_checks++;
        if (alu_result !== e.res || zero_flag !== e.zero || overflow !== e.ovf) begin
          n_errors++;
          $display("FAIL %s: got res=%h z=%b ovf=%b, want res=%h z=%b ovf=%b", e.name,
                   alu_result, zero_flag, overflow, e.res, e.zero, e.ovf);
        end
      end
      if (i < 6) drive(d1[i], d2[i], op[i], rs[i], ov[i], $sformatf("arith_%0d", i));
    end
  endtask

  task automatic test_compare;
    logic [31:0] d1 [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd3};
    logic [31:0] d2 [5] = '{32'h1, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'd3};
    logic [3:0]  op [5] = '{ALU_SLT, ALU_SLTU, ALU_SLT, ALU_SLTU, ALU_SLT};
    logic [31:0] rs [5] = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd0};
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e = sb.pop_front();
        n_checks++;
        if (alu_result !== e.res || zero_flag !== e.zero || overflow !== e.ovf) begin
          n_errors++;
          $display("FAIL %s: got res=%h z=%b ovf=%b, want res=%h z=%b ovf=%b", e.name,
                   alu_result, zero_flag, overflow, e.res, e.zero, e.ovf);
        end
      end
      if (i < 5) drive(d1[i], d2[i], op[i], rs[i], 1'b0, $sformatf("cmp_%0d", i));
    end
  endtask

  task automatic test_shift;
    logic [31:0] d1 [8] = '{32'd4, 32'd4, 32'd4, 32'h24, 32'h24, 32'h24, 32'd0, 32'd31};
    logic [3:0]  op [8] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRA,
                            ALU_SRA};
    logic [31:0] rs [8] = '{32'h00000100, 32'h08000001, 32'hF8000001, 32'h00000100,
                            32'h08000001, 32'hF8000001, 32'h80000010, 32'hFFFFFFFF};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e = sb.pop_front();
        n_checks++;
        if (alu_result !== e.res || zero_flag !== e.zero || overflow !== e.ovf) begin
          n_errors++;
          $display("FAIL %s: got res=%h z=%b ovf=%b, want res=%h z=%b ovf=%b", e.name,
                   alu_result, zero_flag, overflow, e.res, e.zero, e.ovf);
        end
      end
      if (i < 8) drive(d1[i], 32'h80000010, op[i], rs[i], 1'b0, $sformatf("shift_%0d", i));
    end
  endtask

  // Op changes every cycle; each pop checks the result of the previous cycle's inputs.
  task automatic test_back_to_back;
    logic [31:0] d1 [9] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0,
                            32'h12345678, 32'h12345678, 32'h7FFFFFFF, 32'd2};
    logic [31:0] d2 [9] = '{32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                            32'h00001234, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h7FFFFFFF, 32'd3};
    logic [3:0]  op [9] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_LUI, 4'b1111, 4'b1110,
                            ALU_ADD, ALU_ADD};
    logic [31:0] rs [9] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h000F000F,
                            32'h12340000, 32'h0, 32'h0, 32'hFFFFFFFE, 32'd5};
    logic        ov [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e = sb.pop_front();
        n_checks++;
        if (alu_result !== e.res || zero_flag !== e.zero || overflow !== e.ovf) begin
          n_errors++;
          $display("FAIL %s: got res=%h z=%b ovf=%b, want res=%h z=%b ovf=%b", e.name,
                   alu_result, zero_flag, overflow, e.res, e.zero, e.ovf);
        end
      end
      if (i < 9) drive(d1[i], d2[i], op[i], rs[i], ov[i], $sformatf("b2b_%0d", i));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    data1  = '0;
    data2  = '0;
    alu_op = '0;
    test_reset;
    test_add_sub;
    test_compare;
    test_shift;
    test_back_to_back;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
